// File: rtl/chess_host_pkg.sv
// Shared types for the chess chip host link: host opcodes, chip pin opcodes,
// response error codes and the link FSM state encoding.
package chess_host_pkg;

    localparam int SQ_W    = 6;
    localparam int PIECE_W = 4;

    // A legal move needs every bit of the destination square driven by the chip.
    localparam logic [SQ_W-1:0] MOVE_OE_MASK = 6'h3F;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_GO    = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        PIN_IDLE  = 2'b00,
        PIN_WRITE = 2'b01,
        PIN_GO    = 2'b10,
        PIN_READ  = 2'b11
    } pin_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_NO_MOVE = 2'b10,
        ERR_BAD_OP  = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_SAMPLE,
        S_RESP
    } state_e;

    function automatic logic [7:0] pin_word(input pin_op_e op, input logic [SQ_W-1:0] sq);
        return {op, sq};
    endfunction

endpackage

// File: rtl/chess_host_timer.sv
// Saturating wait counter; expired is high during the limit-th enabled cycle
// after a clear, so a wait never lasts longer than limit cycles.
module chess_host_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign count_next = {1'b0, count} + (WIDTH + 1)'(1);
    assign expired    = (count_next >= {1'b0, limit});

endmodule

// File: rtl/chess_host_link.sv
// Host-side bridge to the chess search chip: each accepted host command becomes
// one registered pin operation on the chip and yields exactly one response.
module chess_host_link
    import chess_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int BUSY_WINDOW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [5:0] cmd_sq,
    input  logic [3:0] cmd_piece,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [5:0] resp_from,
    output logic [5:0] resp_to,
    output logic [1:0] resp_err,
    output logic [7:0] dut_ui,
    output logic [7:0] dut_uio,
    input  logic [7:0] dut_uo,
    input  logic [7:0] dut_uio_o,
    input  logic [7:0] dut_uio_oe
);
    localparam int MAX_LIMIT = (TIMEOUT_CYCLES > BUSY_WINDOW) ? TIMEOUT_CYCLES : BUSY_WINDOW;
    localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

    state_e           state;
    cmd_op_e          op_q;
    logic             busy;
    logic             move_ok;
    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_expired;
    logic [CNT_W-1:0] tmr_limit;
    logic             unused_ok;

    assign busy      = dut_uo[7];
    assign move_ok   = dut_uo[6] && (dut_uio_oe[SQ_W-1:0] == MOVE_OE_MASK);
    assign unused_ok = ^{dut_uio_o[7:6], dut_uio_oe[7:6]};

    // Combinational so the link is ready in the very first cycle after reset.
    assign cmd_ready = (state == S_IDLE) && !rst;

    // The counter restarts on the way into each wait and measures against that wait's bound.
    always_comb begin
        tmr_clear  = (state == S_ISSUE) || ((state == S_WAIT_BUSY) && busy);
        tmr_enable = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
        tmr_limit  = (state == S_WAIT_BUSY) ? CNT_W'(BUSY_WINDOW) : CNT_W'(TIMEOUT_CYCLES);
    end

    chess_host_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= CMD_WRITE;
            resp_valid <= 1'b0;
            resp_from  <= '0;
            resp_to    <= '0;
            resp_err   <= ERR_OK;
            dut_ui     <= '0;
            dut_uio    <= '0;
        end else begin
            // NOTE: non-blocking everywhere; these defaults are overridden later in the
            // same block, so the pins are driven for the ISSUE cycle only.
            dut_ui  <= '0;
            dut_uio <= '0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op_e'(cmd_op);
                        state <= S_ISSUE;
                        case (cmd_op_e'(cmd_op))
                            CMD_WRITE: begin
                                dut_ui  <= pin_word(PIN_WRITE, cmd_sq);
                                dut_uio <= {4'b0000, cmd_piece};
                            end
                            CMD_GO:   dut_ui <= pin_word(PIN_GO, '0);
                            CMD_READ: dut_ui <= pin_word(PIN_READ, '0);
                            default:  ;
                        endcase
                    end
                end

                S_ISSUE: begin
                    case (op_q)
                        CMD_GO:   state <= S_WAIT_BUSY;
                        CMD_READ: state <= S_SAMPLE;
                        default: begin
                            resp_valid <= 1'b1;
                            resp_from  <= '0;
                            resp_to    <= '0;
                            resp_err   <= (op_q == CMD_WRITE) ? ERR_OK : ERR_BAD_OP;
                            state      <= S_RESP;
                        end
                    endcase
                end

                S_WAIT_BUSY: begin
                    if (busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmr_expired) begin
                        resp_valid <= 1'b1;
                        resp_from  <= '0;
                        resp_to    <= '0;
                        resp_err   <= ERR_TIMEOUT;
                        state      <= S_RESP;
                    end
                end

                S_WAIT_DONE: begin
                    if (!busy || tmr_expired) begin
                        resp_valid <= 1'b1;
                        resp_from  <= '0;
                        resp_to    <= '0;
                        resp_err   <= busy ? ERR_TIMEOUT : ERR_OK;
                        state      <= S_RESP;
                    end
                end

                S_SAMPLE: begin
                    resp_valid <= 1'b1;
                    resp_from  <= dut_uo[SQ_W-1:0];
                    resp_to    <= dut_uio_o[SQ_W-1:0];
                    resp_err   <= move_ok ? ERR_OK : ERR_NO_MOVE;
                    state      <= S_RESP;
                end

                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chess_host_link.sv
// Scoreboard bench for chess_host_link: two instances (default and short timeout)
// driven against a small behavioural model of the chess chip pins.
module tb_chess_host_link;
    import chess_host_pkg::*;

    localparam int NI       = 2;
    localparam int BW       = 8;
    localparam int TO_SHORT = 16;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        logic [1:0] err;
    } resp_t;

    logic clk = 1'b0;
    logic rst;

    logic       cmd_valid  [NI];
    logic       cmd_ready  [NI];
    logic [1:0] cmd_op     [NI];
    logic [5:0] cmd_sq     [NI];
    logic [3:0] cmd_piece  [NI];
    logic       resp_valid [NI];
    logic       resp_ready [NI];
    logic [5:0] resp_from  [NI];
    logic [5:0] resp_to    [NI];
    logic [1:0] resp_err   [NI];
    logic [7:0] dut_ui     [NI];
    logic [7:0] dut_uio    [NI];
    logic [7:0] dut_uo     [NI];
    logic [7:0] dut_uio_o  [NI];
    logic [7:0] dut_uio_oe [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        chess_host_link #(
            .TIMEOUT_CYCLES (g == 0 ? 65535 : TO_SHORT),
            .BUSY_WINDOW    (BW)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_op     (cmd_op[g]),
            .cmd_sq     (cmd_sq[g]),
            .cmd_piece  (cmd_piece[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_from  (resp_from[g]),
            .resp_to    (resp_to[g]),
            .resp_err   (resp_err[g]),
            .dut_ui     (dut_ui[g]),
            .dut_uio    (dut_uio[g]),
            .dut_uo     (dut_uo[g]),
            .dut_uio_o  (dut_uio_o[g]),
            .dut_uio_oe (dut_uio_oe[g])
        );
    end

    // Chip model: busy rises busy_delay cycles after a GO pin op and lasts busy_len cycles.
    int         go_age     [NI] = '{default: 0};
    bit         go_active  [NI] = '{default: 1'b0};
    int         busy_delay [NI];
    int         busy_len   [NI];
    logic [6:0] uo_lo      [NI];
    logic [7:0] uio_o_m    [NI];
    logic [7:0] oe_m       [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dut_ui[i][7:6] == 2'b10) begin
                go_active[i] <= 1'b1;
                go_age[i]    <= 0;
            end else if (go_active[i] && go_age[i] < (1 << 30)) begin
                go_age[i] <= go_age[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dut_uo[i]     = {go_active[i] && (go_age[i] >= busy_delay[i]) &&
                             ((go_age[i] - busy_delay[i]) < busy_len[i]), uo_lo[i]};
            dut_uio_o[i]  = uio_o_m[i];
            dut_uio_oe[i] = oe_m[i];
        end
    end

    // Pin activity monitor: counts cycles with any nonzero pin drive.
    int         pin_cnt [NI] = '{default: 0};
    logic [7:0] pin_ui  [NI];
    logic [7:0] pin_uio [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dut_ui[i] != 8'h00 || dut_uio[i] != 8'h00) begin
                pin_cnt[i] = pin_cnt[i] + 1;
                pin_ui[i]  = dut_ui[i];
                pin_uio[i] = dut_uio[i];
            end
        end
    end

    resp_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic resp_t mk(input logic [5:0] s, input logic [5:0] d, input err_e e);
        resp_t r;
        r.src = s;
        r.dst = d;
        r.err = e;
        return r;
    endfunction

    // Offer a command, wait (bounded) for acceptance, optionally record the expected response.
    task automatic issue(input int i, input cmd_op_e op, input logic [5:0] sq, input logic [3:0] pc,
                         input bit expect_resp, input resp_t exp, output int pins_before);
        int waited = 0;
        @(negedge clk);
        cmd_valid[i] = 1'b1;
        cmd_op[i]    = op;
        cmd_sq[i]    = sq;
        cmd_piece[i] = pc;
        while (!cmd_ready[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        pins_before = pin_cnt[i];
        check("cmd_accept", 32'(cmd_ready[i]), 32'd1);
        if (cmd_ready[i]) begin
            if (expect_resp) exp_q.push_back(exp);
            @(posedge clk);
        end
        #1 cmd_valid[i] = 1'b0;
    endtask

    // Latency counted in cycles after the acceptance edge (1 = the ISSUE cycle).
    task automatic wait_resp(input int i, input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            @(negedge clk);
            #1;
            lat++;
            if (resp_valid[i]) break;
        end
        check("resp_seen", 32'(resp_valid[i]), 32'd1);
    endtask

    // Compare against the scoreboard head, optionally stalling resp_ready, then consume.
    task automatic consume(input int i, input int hold, input bit with_cmd);
        resp_t exp;
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        exp = exp_q.pop_front();
        for (int k = 0; k < hold; k++) begin
            check("hold_valid", 32'(resp_valid[i]), 32'd1);
            check("hold_data", 32'({resp_from[i], resp_to[i], resp_err[i]}), 32'(exp));
            @(negedge clk);
            #1;
        end
        check("resp_from", 32'(resp_from[i]), 32'(exp.src));
        check("resp_to", 32'(resp_to[i]), 32'(exp.dst));
        check("resp_err", 32'(resp_err[i]), 32'(exp.err));
        check("cmd_ready_in_resp", 32'(cmd_ready[i]), 32'd0);
        resp_ready[i] = 1'b1;
        if (with_cmd) begin
            cmd_valid[i] = 1'b1;
            cmd_op[i]    = CMD_RSVD;
        end
        @(posedge clk);
        #1 resp_ready[i] = 1'b0;
        check("resp_dropped", 32'(resp_valid[i]), 32'd0);
        if (with_cmd) check("cmd_held_off", 32'(cmd_ready[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pb;
        int seen;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            cmd_valid[i]  = 1'b0;
            cmd_op[i]     = 2'b00;
            cmd_sq[i]     = '0;
            cmd_piece[i]  = '0;
            resp_ready[i] = 1'b0;
            busy_delay[i] = 3;
            busy_len[i]   = 0;
            uo_lo[i]      = '0;
            uio_o_m[i]    = '0;
            oe_m[i]       = '0;
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_cmd_ready", 32'(cmd_ready[i]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            check("rst_pins", 32'({dut_ui[i], dut_uio[i]}), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(cmd_ready[0]), 32'd1);

        // Write square 12 with piece 5.
        issue(0, CMD_WRITE, 6'd12, 4'd5, 1'b1, mk(6'd0, 6'd0, ERR_OK), pb);
        wait_resp(0, 20, lat);
        check("wr_lat", lat, 2);
        check("wr_pin_cycles", pin_cnt[0] - pb, 1);
        check("wr_ui", 32'(pin_ui[0]), 32'h4C);
        check("wr_uio", 32'(pin_uio[0]), 32'h05);
        consume(0, 0, 1'b0);

        // Go with a 100-cycle search; host stalls resp_ready for 5 cycles.
        busy_delay[0] = 3;
        busy_len[0]   = 100;
        issue(0, CMD_GO, 6'd0, 4'd0, 1'b1, mk(6'd0, 6'd0, ERR_OK), pb);
        wait_resp(0, 400, lat);
        check("go_after_busy", 32'(lat >= 103), 32'd1);
        check("go_pin_cycles", pin_cnt[0] - pb, 1);
        check("go_ui", 32'(pin_ui[0]), 32'h80);
        consume(0, 5, 1'b0);

        // Go where busy never rises.
        busy_len[0] = 0;
        issue(0, CMD_GO, 6'd0, 4'd0, 1'b1, mk(6'd0, 6'd0, ERR_TIMEOUT), pb);
        wait_resp(0, 100, lat);
        check("nobusy_lat", 32'(lat >= BW + 2 && lat <= BW + 3), 32'd1);
        consume(0, 0, 1'b0);

        // Go where busy sticks high, short-timeout instance.
        busy_delay[1] = 3;
        busy_len[1]   = 1 << 30;
        issue(1, CMD_GO, 6'd0, 4'd0, 1'b1, mk(6'd0, 6'd0, ERR_TIMEOUT), pb);
        wait_resp(1, 200, lat);
        check("stuck_lat", 32'(lat >= TO_SHORT + 4 && lat <= TO_SHORT + BW + 4), 32'd1);
        consume(1, 0, 1'b0);
        busy_len[1] = 0;

        // Read a legal move 12 -> 28.
        uo_lo[0]   = 7'h4C;
        uio_o_m[0] = 8'h1C;
        oe_m[0]    = 8'h3F;
        issue(0, CMD_READ, 6'd0, 4'd0, 1'b1, mk(6'd12, 6'd28, ERR_OK), pb);
        wait_resp(0, 20, lat);
        check("rd_lat", lat, 3);
        check("rd_pin_cycles", pin_cnt[0] - pb, 1);
        check("rd_ui", 32'({pin_ui[0], pin_uio[0]}), 32'hC000);
        consume(0, 0, 1'b0);

        // Reset in WAIT_DONE: everything clears and the response is never produced.
        busy_len[0] = 100;
        issue(0, CMD_GO, 6'd0, 4'd0, 1'b0, mk(6'd0, 6'd0, ERR_OK), pb);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        check("mid_rst_resp", 32'({resp_valid[0], resp_from[0], resp_to[0], resp_err[0]}), 32'd0);
        check("mid_rst_pins", 32'({dut_ui[0], dut_uio[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", 32'(cmd_ready[0]), 32'd1);
        seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        check("mid_rst_no_resp", seen, 0);

        // Read with move-valid low.
        uo_lo[0] = 7'h0C;
        issue(0, CMD_READ, 6'd0, 4'd0, 1'b1, mk(6'd12, 6'd28, ERR_NO_MOVE), pb);
        wait_resp(0, 20, lat);
        consume(0, 0, 1'b0);

        // Read with an incomplete output enable, then a reserved opcode offered alongside resp_ready.
        uo_lo[0] = 7'h4C;
        oe_m[0]  = 8'h1F;
        issue(0, CMD_READ, 6'd0, 4'd0, 1'b1, mk(6'd12, 6'd28, ERR_NO_MOVE), pb);
        wait_resp(0, 20, lat);
        check("rd_oe_lat", lat, 3);
        consume(0, 0, 1'b1);
        pb = pin_cnt[0];
        exp_q.push_back(mk(6'd0, 6'd0, ERR_BAD_OP));
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        wait_resp(0, 20, lat);
        check("badop_lat", lat, 2);
        check("badop_pin_cycles", pin_cnt[0] - pb, 0);
        consume(0, 0, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chess_host_link.md
CHESS_HOST_LINK -- requirements
Module: chess_host_link

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, max cycles the search-done wait (WAIT_DONE) lasts before error.
REQ-002 SHALL have parameter BUSY_WINDOW, default 8, max cycles from GO issue to busy rising.
REQ-003 SHALL have port clk  in  1  sole clock.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  host command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_op  in  2  00 write square, 01 go, 10 read move, 11 reserved.
REQ-008 SHALL have port cmd_sq  in  6  square index for write.
REQ-009 SHALL have port cmd_piece  in  4  piece code for write.
REQ-010 SHALL have port resp_valid  out  1  response offered.
REQ-011 SHALL have port resp_ready  in  1  host consumes response.
REQ-012 SHALL have port resp_from  out  6  move source square.
REQ-013 SHALL have port resp_to  out  6  move destination square.
REQ-014 SHALL have port resp_err  out  2  00 ok, 01 timeout, 10 no move, 11 bad opcode.
REQ-015 SHALL have port dut_ui  out  8  drives chess chip ui_in; [7:6] pin op (00 idle, 01 write, 10 go, 11 read), [5:0] square.
REQ-016 SHALL have port dut_uio  out  8  drives chip uio_in; [3:0] piece, [7:4] zero.
REQ-017 SHALL have port dut_uo  in  8  chip uo_out; [7] busy, [6] move valid, [5:0] from square.
REQ-018 SHALL have ports dut_uio_o  in  8  chip uio_out ([5:0] to square) and dut_uio_oe  in  8  chip uio_oe.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, SAMPLE, RESP.
REQ-020 SHALL assert cmd_ready only in IDLE; handshake at cycle N -> ISSUE at N+1.
REQ-021 SHALL register dut_ui/dut_uio; nonzero only during the single ISSUE cycle, zero otherwise.
REQ-022 Write: ISSUE drives dut_ui={01,sq}, dut_uio={0,piece}; then RESP with err 00, from/to 0; resp_valid at N+2.
REQ-023 Go: ISSUE drives dut_ui=8'h80; WAIT_BUSY until dut_uo[7]=1, err 01 if not seen within BUSY_WINDOW cycles; WAIT_DONE until dut_uo[7]=0, err 01 if still busy after TIMEOUT_CYCLES; then RESP err 00.
REQ-024 Read: ISSUE drives dut_ui=8'hC0; SAMPLE captures dut_uo[5:0]->resp_from, dut_uio_o[5:0]->resp_to; err 10 if dut_uo[6]=0 or dut_uio_oe[5:0]!=6'h3F; resp_valid at N+3.
REQ-025 Opcode 11: no pin activity; RESP err 11 at N+2.
REQ-026 Timeout counter SHALL clear on entry to WAIT_BUSY/WAIT_DONE, increment per waiting cycle, never wrap.
REQ-027 resp_* SHALL hold stable while resp_valid=1 and resp_ready=0; RESP->IDLE on resp_ready.
REQ-028 cmd_valid in same cycle as resp_ready SHALL not be accepted; earliest acceptance next cycle.
REQ-029 dut_* inputs SHALL be same-clock-domain; no synchronizer stages.

Reset
REQ-030 rst SHALL force IDLE, cmd_ready=0 during rst, resp_valid=0, resp_from/to/err=0, dut_ui/dut_uio=0, counter=0 at the next edge.
REQ-031 rst mid-operation SHALL abandon the command and drop any pending response; cmd_ready=1 first cycle after rst deasserts.

Structure
REQ-032 Package chess_host_pkg SHALL hold cmd opcode, pin opcode, error code and FSM state enums.
REQ-033 Timeout counter SHALL be sub-module chess_host_timer (clear, enable, limit, expired).

Verification
REQ-034 Write sq=12 piece=5 -> one cycle dut_ui=8'h4C, dut_uio=8'h05; resp err 00 at N+2.
REQ-035 Go, model busy high 3 cycles after issue for 100 cycles -> resp err 00 after busy falls.
REQ-036 Go, busy never rises -> resp err 01 after BUSY_WINDOW=8 cycles; stuck busy, TIMEOUT_CYCLES=16 -> err 01.
REQ-037 Read, model uo=8'h4C, uio_out=8'h1C, oe=8'h3F -> resp from=12, to=28, err 00; uo[6]=0 -> err 10.
REQ-038 resp_ready held low 5 cycles -> resp stable; rst asserted in WAIT_DONE -> all outputs 0, no response.
